data_mem_responder: RTL and testbench

//  Responder end of the CPU data-memory port (data_w, 16-bit address, 8-bit din/dout).

---
 rtl/data_mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the CPU data-memory port. Byte-wide RAM with an async read
//   port. The RAM is loaded over a host valid/ready write stream. The CPU then
//   runs while cpu_enable is high. After finish, a fixed window of the RAM is
//   dumped over a host valid/ready read stream.
//
//   Optional macro DUMP_CHECKSUM_EN: appends an XOR checksum byte to every dump,
//   and host_rlast moves to that byte.
//
// Ports
//   clk, reset           system clock; synchronous active-low reset
//   data_w, addr_data_ram, din_data_ram, dout_data_ram
//                        CPU data port (write enable, byte address, wdata, rdata)
//   finish               CPU end-of-program
//   cpu_enable           CPU clock enable, high only in RUN
//   host_start           begins a load (IDLE only)
//   host_wvalid/wready/wdata/wlast   load stream
//   host_rvalid/rready/rdata/rlast   dump stream
//   load_ovf             sticky: load pointer wrapped
//   state                IDLE=0 LOAD=1 RUN=2 DUMP=3
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | waiting for host_start
// LOAD  | host stream writes RAM, wlast ends the load
// RUN   | CPU owns the RAM, finish ends the run
// DUMP  | window streamed to host, last handshake -> IDLE

module data_mem_responder #(
    parameter int          ADDR_W    = 12,
    parameter logic [15:0] DUMP_BASE = 16'h0,
    parameter int          DUMP_LEN  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_w,
    input  logic [15:0] addr_data_ram,
    input  logic [7:0]  din_data_ram,
    output logic [7:0]  dout_data_ram,
    input  logic        finish,
    output logic        cpu_enable,
    input  logic        host_start,
    input  logic        host_wvalid,
    input  logic [7:0]  host_wdata,
    input  logic        host_wlast,
    output logic        host_wready,
    output logic        host_rvalid,
    output logic [7:0]  host_rdata,
    output logic        host_rlast,
    input  logic        host_rready,
    output logic        load_ovf,
    output logic [1:0]  state
);

    localparam int                  DEPTH  = 1 << ADDR_W;
    localparam int                  CNT_W  = ADDR_W + 1;
    localparam logic [ADDR_W-1:0]   BASE_A = DUMP_BASE[ADDR_W-1:0];
    localparam logic [CNT_W-1:0]    LEN_C  = CNT_W'(DUMP_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DUMP = 2'd3
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] lptr;
    logic [ADDR_W-1:0] rptr;
    logic [CNT_W-1:0]  remaining;   // data bytes not yet presented
    logic              load_acc;
    logic              cpu_wr;
    logic              rd_hs;
    logic              present;     // load the next byte into the output register
    logic              unused_addr_hi;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign state          = cur_state;
    assign dout_data_ram  = mem[addr_data_ram[ADDR_W-1:0]];
    assign unused_addr_hi = ^addr_data_ram[15:ADDR_W];

    // state register
    always_ff @(posedge clk) begin
        if (!reset) cur_state <= S_IDLE;
        else        cur_state <= nxt_state;
    end

    // next-state logic
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE: if (host_start)                 nxt_state = S_LOAD;
            S_LOAD: if (host_wvalid && host_wlast)  nxt_state = S_RUN;
            S_RUN:  if (finish)                     nxt_state = S_DUMP;
            S_DUMP: if (rd_hs && host_rlast)        nxt_state = S_IDLE;
            default:                                nxt_state = S_IDLE;
        endcase
    end

    // output / strobe logic
    always_comb begin
        host_wready = 1'b0;
        load_acc    = 1'b0;
        cpu_wr      = 1'b0;
        rd_hs       = 1'b0;
        present     = 1'b0;
        host_wready = (cur_state == S_LOAD);
        load_acc    = host_wready && host_wvalid;
        cpu_wr      = (cur_state == S_RUN) && data_w;
        rd_hs       = host_rvalid && host_rready;
        // first DUMP cycle, or a non-final handshake: refill the output register
        present     = (cur_state == S_DUMP) && (!host_rvalid || (rd_hs && !host_rlast));
    end

    // RAM is never cleared; writes are suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (reset) begin
            if (load_acc)    mem[lptr] <= host_wdata;
            else if (cpu_wr) mem[addr_data_ram[ADDR_W-1:0]] <= din_data_ram;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_enable  <= 1'b0;
            lptr        <= '0;
            load_ovf    <= 1'b0;
            rptr        <= '0;
            remaining   <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= 8'h00;
            host_rlast  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum        <= 8'h00;
`endif
        end else begin
            // registered from next state: rises on RUN entry, falls with finish
            cpu_enable <= (nxt_state == S_RUN);

            if (cur_state == S_IDLE && host_start) begin
                lptr     <= '0;
                load_ovf <= 1'b0;
            end
            if (load_acc) begin
                lptr <= lptr + ADDR_W'(1);
                if (lptr == '1) load_ovf <= 1'b1;
            end

            if (cur_state == S_RUN && finish) begin
                rptr      <= BASE_A;
                remaining <= LEN_C;
`ifdef DUMP_CHECKSUM_EN
                csum      <= 8'h00;
`endif
            end

            if (present) begin
                host_rvalid <= 1'b1;
                if (remaining != '0) begin
                    host_rdata <= mem[rptr];
                    rptr       <= rptr + ADDR_W'(1);
                    remaining  <= remaining - CNT_W'(1);
`ifdef DUMP_CHECKSUM_EN
                    csum       <= csum ^ mem[rptr];
                    host_rlast <= 1'b0;
`else
                    host_rlast <= (remaining == CNT_W'(1));
`endif
                end else begin
`ifdef DUMP_CHECKSUM_EN
                    host_rdata <= csum;
`endif
                    host_rlast <= 1'b1;
                end
            end else if (rd_hs && host_rlast) begin
                host_rvalid <= 1'b0;
                host_rlast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;

    // DUT A: ADDR_W=12, 16-byte dump from 0
    logic        data_w;
    logic [15:0] addr_data_ram;
    logic [7:0]  din_data_ram;
    logic [7:0]  dout_data_ram;
    logic        finish;
    logic        cpu_enable;
    logic        host_start;
    logic        host_wvalid;
    logic [7:0]  host_wdata;
    logic        host_wlast;
    logic        host_wready;
    logic        host_rvalid;
    logic [7:0]  host_rdata;
    logic        host_rlast;
    logic        host_rready;
    logic        load_ovf;
    logic [1:0]  state_a;

    // DUT B: ADDR_W=4, 3-byte dump from 0
    logic        b_data_w;
    logic [15:0] b_addr;
    logic [7:0]  b_din;
    logic [7:0]  b_dout;
    logic        b_finish;
    logic        b_cpu_enable;
    logic        b_start;
    logic        b_wvalid;
    logic [7:0]  b_wdata;
    logic        b_wlast;
    logic        b_wready;
    logic        b_rvalid;
    logic [7:0]  b_rdata;
    logic        b_rlast;
    logic        b_rready;
    logic        b_load_ovf;
    logic [1:0]  b_state;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] buf_a [0:16];
    logic [7:0] exp_a [0:16];
    int         n_exp;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  din;
        logic [7:0]  dout;
    } vec_t;
    vec_t tbl [9];

    data_mem_responder #(.ADDR_W(12), .DUMP_BASE(16'h0), .DUMP_LEN(16)) dut_a (
        .clk(clk), .reset(reset), .data_w(data_w), .addr_data_ram(addr_data_ram),
        .din_data_ram(din_data_ram), .dout_data_ram(dout_data_ram), .finish(finish),
        .cpu_enable(cpu_enable), .host_start(host_start), .host_wvalid(host_wvalid),
        .host_wdata(host_wdata), .host_wlast(host_wlast), .host_wready(host_wready),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_rlast(host_rlast),
        .host_rready(host_rready), .load_ovf(load_ovf), .state(state_a)
    );

    data_mem_responder #(.ADDR_W(4), .DUMP_BASE(16'h0), .DUMP_LEN(3)) dut_b (
        .clk(clk), .reset(reset), .data_w(b_data_w), .addr_data_ram(b_addr),
        .din_data_ram(b_din), .dout_data_ram(b_dout), .finish(b_finish),
        .cpu_enable(b_cpu_enable), .host_start(b_start), .host_wvalid(b_wvalid),
        .host_wdata(b_wdata), .host_wlast(b_wlast), .host_wready(b_wready),
        .host_rvalid(b_rvalid), .host_rdata(b_rdata), .host_rlast(b_rlast),
        .host_rready(b_rready), .load_ovf(b_load_ovf), .state(b_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic load_a(input int n);
        @(negedge clk); host_start = 1'b1;
        @(negedge clk); host_start = 1'b0;
        chk("load_state", 32'(state_a), 32'd1);
        chk("load_wready", 32'(host_wready), 32'd1);
        for (int i = 0; i < n; i++) begin
            host_wvalid = 1'b1;
            host_wdata  = buf_a[i];
            host_wlast  = (i == n - 1);
            @(negedge clk);
        end
        host_wvalid = 1'b0;
        host_wlast  = 1'b0;
        chk("run_state", 32'(state_a), 32'd2);
        chk("run_cpu_en", 32'(cpu_enable), 32'd1);
        chk("load_ovf_clr", 32'(load_ovf), 32'd0);
    endtask

    task automatic finish_a(input logic we, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        finish = 1'b1; data_w = we; addr_data_ram = a; din_data_ram = d;
        chk("fin_cpu_en_before", 32'(cpu_enable), 32'd1);
        @(negedge clk);
        finish = 1'b0; data_w = 1'b0;
        chk("fin_state", 32'(state_a), 32'd3);
        chk("fin_cpu_en_after", 32'(cpu_enable), 32'd0);
        chk("fin_rvalid_first", 32'(host_rvalid), 32'd0);
    endtask

    // mode 0: stall 5 cycles before byte 4; mode 1: random rready
    task automatic dump_a(input int mode);
        int         idx = 0;
        int         cyc = 0;
        int         stall = 0;
        logic       pstall = 1'b0;
        logic [7:0] pd = 8'h00;
        logic       pl = 1'b0;
        logic       rr;
        while (idx < n_exp && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (pstall) begin
                chk("hold_rdata", 32'(host_rdata), 32'(pd));
                chk("hold_rlast", 32'(host_rlast), 32'(pl));
            end
            rr = 1'b1;
            if (mode == 0 && idx == 4 && stall < 5) begin
                rr = 1'b0;
                stall++;
            end else if (mode == 1) begin
                rr = 1'($urandom_range(0, 1));
            end
            host_rready = rr;
            if (host_rvalid && rr) begin
                chk("dump_rdata", 32'(host_rdata), 32'(exp_a[idx]));
                chk("dump_rlast", 32'(host_rlast), 32'(idx == n_exp - 1));
                idx++;
            end
            pstall = host_rvalid && !rr;
            pd     = host_rdata;
            pl     = host_rlast;
        end
        chk("dump_count", 32'(idx), 32'(n_exp));
        @(negedge clk);
        host_rready = 1'b0;
        chk("dump_end_state", 32'(state_a), 32'd0);
        chk("dump_end_rvalid", 32'(host_rvalid), 32'd0);
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] bexp [0:3];
        int         nb;
        int         idx;

        tbl[0] = '{1'b1, 16'h0005, 8'hA5, 8'hA5};
        tbl[1] = '{1'b0, 16'h1005, 8'h00, 8'hA5};
        tbl[2] = '{1'b0, 16'h0000, 8'h00, 8'h11};
        tbl[3] = '{1'b0, 16'h0001, 8'h00, 8'h22};
        tbl[4] = '{1'b0, 16'h0002, 8'h00, 8'h33};
        tbl[5] = '{1'b1, 16'hF002, 8'h5A, 8'h5A};
        tbl[6] = '{1'b0, 16'h0002, 8'h00, 8'h5A};
        tbl[7] = '{1'b1, 16'h0FFF, 8'hC3, 8'hC3};
        tbl[8] = '{1'b0, 16'h1FFF, 8'h00, 8'hC3};

        reset = 1'b0;
        data_w = 0; addr_data_ram = 0; din_data_ram = 0; finish = 0;
        host_start = 0; host_wvalid = 0; host_wdata = 0; host_wlast = 0; host_rready = 0;
        b_data_w = 0; b_addr = 0; b_din = 0; b_finish = 0;
        b_start = 0; b_wvalid = 0; b_wdata = 0; b_wlast = 0; b_rready = 0;

        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state_a), 32'd0);
        chk("rst_cpu_en", 32'(cpu_enable), 32'd0);
        chk("rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_rlast", 32'(host_rlast), 32'd0);
        chk("rst_rdata", 32'(host_rdata), 32'd0);
        chk("rst_ovf", 32'(load_ovf), 32'd0);
        reset = 1'b1;

        // load 11,22,33 then CPU access table
        buf_a[0] = 8'h11; buf_a[1] = 8'h22; buf_a[2] = 8'h33;
        load_a(3);
        foreach (tbl[i]) begin
            @(negedge clk);
            data_w = tbl[i].we; addr_data_ram = tbl[i].addr; din_data_ram = tbl[i].din;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_dout", i), 32'(dout_data_ram), 32'(tbl[i].dout));
        end

        // fill 0..14 from the CPU; byte 15 is written on the finish edge
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            data_w = 1'b1; addr_data_ram = 16'(i); din_data_ram = 8'(i);
        end
        finish_a(1'b1, 16'h000F, 8'h0F);
        chk("fin_write_commit", 32'(dout_data_ram), 32'h0F);

        x = 8'h00;
        for (int i = 0; i < 16; i++) begin
            exp_a[i] = 8'(i);
            x ^= 8'(i);
        end
        n_exp = 16;
`ifdef DUMP_CHECKSUM_EN
        exp_a[16] = x;
        n_exp = 17;
`endif
        dump_a(0);

        // second run: host-loaded pattern, random backpressure
        x = 8'h00;
        for (int i = 0; i < 16; i++) begin
            buf_a[i] = 8'(i * 7 + 3);
            exp_a[i] = buf_a[i];
            x ^= buf_a[i];
        end
        n_exp = 16;
`ifdef DUMP_CHECKSUM_EN
        exp_a[16] = x;
        n_exp = 17;
`endif
        load_a(16);
        finish_a(1'b0, 16'h0000, 8'h00);
        dump_a(1);

        // data_w in IDLE is ignored
        @(negedge clk);
        data_w = 1'b1; addr_data_ram = 16'h0000; din_data_ram = 8'hFF;
        @(posedge clk); #1;
        chk("idle_wr_ignored", 32'(dout_data_ram), 32'h03);
        @(negedge clk); data_w = 1'b0;

        // reset from RUN, RAM retained
        buf_a[0] = 8'h99;
        load_a(1);
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2_state", 32'(state_a), 32'd0);
        chk("rst2_cpu_en", 32'(cpu_enable), 32'd0);
        chk("rst2_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst2_ram_kept", 32'(dout_data_ram), 32'h99);
        reset = 1'b1;

        // DUT B: 17-byte load into a 16-byte RAM
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b_wvalid = 1'b1;
            b_wdata  = (i == 0) ? 8'hEE : (i == 1) ? 8'h02 : (i == 2) ? 8'h04 :
                       (i == 16) ? 8'h01 : 8'(8'h40 + i);
            b_wlast  = (i == 16);
            @(negedge clk);
        end
        b_wvalid = 1'b0; b_wlast = 1'b0;
        chk("b_state_run", 32'(b_state), 32'd2);
        chk("b_load_ovf", 32'(b_load_ovf), 32'd1);
        chk("b_mem0_wrapped", 32'(b_dout), 32'h01);

        bexp[0] = 8'h01; bexp[1] = 8'h02; bexp[2] = 8'h04; bexp[3] = 8'h07;
        nb = 3;
`ifdef DUMP_CHECKSUM_EN
        nb = 4;
`endif
        b_finish = 1'b1;
        @(negedge clk); b_finish = 1'b0;
        chk("b_state_dump", 32'(b_state), 32'd3);
        b_rready = 1'b1;
        idx = 0;
        for (int c = 0; c < 20 && idx < nb; c++) begin
            @(negedge clk);
            if (b_rvalid) begin
                chk("b_rdata", 32'(b_rdata), 32'(bexp[idx]));
                chk("b_rlast", 32'(b_rlast), 32'(idx == nb - 1));
                idx++;
            end
        end
        chk("b_count", 32'(idx), 32'(nb));
        @(negedge clk); b_rready = 1'b0;
        chk("b_end_state", 32'(b_state), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
